// File: rtl/mux_arb_pkg.sv
// Shared definitions for the two-source round-robin mux arbiter.
// State encoding is fixed so debug probes and checkers can decode dbg_state.
package mux_arb_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT_A = 2'd1,
        ST_GRANT_B = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mux_bank.sv
// WIDTH-wide bank of 2:1 bit muxes sharing one select line.
// sel=0 passes in_a, sel=1 passes in_b; purely combinational.
module mux_bank #(
    parameter int WIDTH = 16
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] out_data
);

    // One 2:1 mux per data bit, all steered by the same select.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign out_data[i] = sel ? in_b[i] : in_a[i];
    end

endmodule

// File: rtl/mux_arbiter.sv
// Two-requester round-robin arbiter in front of a shared WIDTH-bit 2:1 mux.
//
// Handshake: a source's data moves on a cycle where its Valid and its Ready
// are both high; the output moves when OutValid and OutReady are both high.
// A source's Ready is only ever raised while it holds the grant, so the two
// source Readys are mutually exclusive and each mirrors the output handshake.
//
// Optional build macro MUX_ARB_STATS_EN adds saturating per-source transfer
// counters (ACount/BCount, CNT_WIDTH bits). Without it those ports do not exist.
//
// dbg_state / dbg_pri expose the FSM state and the round-robin priority flag.
module mux_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
`ifdef MUX_ARB_STATS_EN
    ,
    parameter int CNT_WIDTH = 16
`endif
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 AValid,
    input  logic [WIDTH-1:0]     AData,
    output logic                 AReady,
    input  logic                 BValid,
    input  logic [WIDTH-1:0]     BData,
    output logic                 BReady,
    output logic                 OutValid,
    output logic [WIDTH-1:0]     OutData,
    input  logic                 OutReady,
    output logic                 Select,
    output logic [1:0]           dbg_state,
    output logic                 dbg_pri
`ifdef MUX_ARB_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] ACount,
    output logic [CNT_WIDTH-1:0] BCount
`endif
);

    arb_state_e state_q, state_d;
    logic       pri_q, pri_d;
    logic       select_q, select_d;
    logic       grant_a, grant_b;
    logic       hs;

    // Grant decode, handshake signals and next-state / priority selection.
    always_comb begin
        grant_a  = (state_q == ST_GRANT_A);
        grant_b  = (state_q == ST_GRANT_B);
        OutValid = (grant_a & AValid) | (grant_b & BValid);
        AReady   = grant_a & AValid & OutReady;
        BReady   = grant_b & BValid & OutReady;
        hs       = OutValid & OutReady;
        state_d  = state_q;
        pri_d    = pri_q;
        case (state_q)
            ST_IDLE: begin
                if (AValid && BValid) begin
                    state_d = pri_q ? ST_GRANT_B : ST_GRANT_A;
                end else if (AValid) begin
                    state_d = ST_GRANT_A;
                end else if (BValid) begin
                    state_d = ST_GRANT_B;
                end
            end
            ST_GRANT_A: begin
                if (hs) begin
                    pri_d   = 1'b1;
                    state_d = BValid ? ST_GRANT_B : ST_IDLE;
                end else if (!AValid) begin
                    // Source withdrew before being accepted: release the mux.
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT_B: begin
                if (hs) begin
                    pri_d   = 1'b0;
                    state_d = AValid ? ST_GRANT_A : ST_IDLE;
                end else if (!BValid) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Select is registered alongside the state so it never sees input glitches.
        select_d = (state_d == ST_GRANT_B);
    end

    // FSM, priority flag and registered mux select.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q  <= ST_IDLE;
            pri_q    <= 1'b0;
            select_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pri_q    <= pri_d;
            select_q <= select_d;
        end
    end

    assign Select    = select_q;
    assign dbg_state = state_q;
    assign dbg_pri   = pri_q;

    mux_bank #(
        .WIDTH (WIDTH)
    ) u_mux_bank (
        .sel      (select_q),
        .in_a     (AData),
        .in_b     (BData),
        .out_data (OutData)
    );

`ifdef MUX_ARB_STATS_EN
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] acnt_q, acnt_d;
    logic [CNT_WIDTH-1:0] bcnt_q, bcnt_d;

    // Saturating transfer counters, stepped on each source's handshake.
    always_comb begin
        acnt_d = acnt_q;
        bcnt_d = bcnt_q;
        if (AReady && (acnt_q != {CNT_WIDTH{1'b1}})) begin
            acnt_d = acnt_q + CNT_ONE;
        end
        if (BReady && (bcnt_q != {CNT_WIDTH{1'b1}})) begin
            bcnt_d = bcnt_q + CNT_ONE;
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            acnt_q <= '0;
            bcnt_q <= '0;
        end else begin
            acnt_q <= acnt_d;
            bcnt_q <= bcnt_d;
        end
    end

    assign ACount = acnt_q;
    assign BCount = bcnt_q;
`endif

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter: scoreboard of expected {Select, OutData}
// per output handshake, plus cycle-level checks of grant, select and priority.
module tb_mux_arbiter;

    localparam int W = 16;

    logic         Clk;
    logic         Rst_n;
    logic         AValid;
    logic [W-1:0] AData;
    logic         AReady;
    logic         BValid;
    logic [W-1:0] BData;
    logic         BReady;
    logic         OutValid;
    logic [W-1:0] OutData;
    logic         OutReady;
    logic         Select;
    logic [1:0]   dbg_state;
    logic         dbg_pri;
`ifdef MUX_ARB_STATS_EN
    logic [3:0]   ACount;
    logic [3:0]   BCount;
`endif

    int checks   = 0;
    int failures = 0;

    // Expected output handshakes: {source select, data}
    logic [W:0] exp_q[$];

    mux_arbiter #(
        .WIDTH (W)
`ifdef MUX_ARB_STATS_EN
        ,
        .CNT_WIDTH (4)
`endif
    ) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .AValid    (AValid),
        .AData     (AData),
        .AReady    (AReady),
        .BValid    (BValid),
        .BData     (BData),
        .BReady    (BReady),
        .OutValid  (OutValid),
        .OutData   (OutData),
        .OutReady  (OutReady),
        .Select    (Select),
        .dbg_state (dbg_state),
        .dbg_pri   (dbg_pri)
`ifdef MUX_ARB_STATS_EN
        ,
        .ACount    (ACount),
        .BCount    (BCount)
`endif
    );

    // Clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge; inputs change only here.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input logic sel, input logic [W-1:0] data);
        exp_q.push_back({sel, data});
    endtask

    // Monitor: mid-cycle, compare every output handshake against the scoreboard.
    initial begin
        logic [W:0] exp;
        forever begin
            @(negedge Clk);
            if (AReady && BReady) begin
                check("both_ready", {30'd0, AReady, BReady}, 32'd2);
            end
            if (OutValid && OutReady) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_hs", {15'd0, Select, OutData}, 32'hFFFF_FFFF);
                end else begin
                    exp = exp_q.pop_front();
                    check("hs_data", {15'd0, Select, OutData}, {15'd0, exp});
                    check("hs_src_ready", {31'd0, (exp[W] ? BReady : AReady)}, 32'd1);
                end
            end
        end
    end

    // Driver
    initial begin
        Rst_n    = 1'b0;
        AValid   = 1'b1;
        BValid   = 1'b1;
        AData    = 16'h1234;
        BData    = 16'hABCD;
        OutReady = 1'b1;

        // Reset held 2 cycles with both sources requesting.
        step();
        step();
        check("rst_outvalid", {31'd0, OutValid}, 32'd0);
        check("rst_select",   {31'd0, Select},   32'd0);
        check("rst_areadyy",  {31'd0, AReady},   32'd0);
        check("rst_bready",   {31'd0, BReady},   32'd0);
        check("rst_state",    {30'd0, dbg_state}, 32'd0);
        Rst_n = 1'b1;

        // Contention: A first after reset, then strict alternation.
        push(1'b0, 16'h1234);
        push(1'b1, 16'hABCD);
        push(1'b0, 16'h1234);
        push(1'b1, 16'hABCD);
        push(1'b0, 16'h1234);
        for (int i = 0; i < 5; i++) begin
            step();
            check("cont_select", {31'd0, Select}, (i % 2 == 1) ? 32'd1 : 32'd0);
            check("cont_outvalid", {31'd0, OutValid}, 32'd1);
            if (i == 4) BValid = 1'b0;
        end
        step();
        check("cont_end_state", {30'd0, dbg_state}, 32'd0);
        check("cont_end_pri",   {31'd0, dbg_pri},   32'd1);
        AValid = 1'b0;

        // Backpressure: A granted, held 3 cycles with B waiting.
        step();
        AValid   = 1'b1;
        AData    = 16'h1234;
        OutReady = 1'b0;
        push(1'b0, 16'h1234);
        push(1'b1, 16'hABCD);
        step();
        BValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            #1;
            check("bp_select",  {31'd0, Select},   32'd0);
            check("bp_data",    {16'd0, OutData},  32'h1234);
            check("bp_ready",   {30'd0, AReady, BReady}, 32'd0);
            check("bp_outvalid", {31'd0, OutValid}, 32'd1);
        end
        OutReady = 1'b1;
        step();
        check("bp_b_granted", {31'd0, Select}, 32'd1);
        AValid = 1'b0;
        step();
        check("bp_end_state", {30'd0, dbg_state}, 32'd0);
        check("bp_end_pri",   {31'd0, dbg_pri},   32'd0);
        BValid = 1'b0;

        // Single source B: one transfer every other cycle.
        step();
        BValid = 1'b1;
        BData  = 16'h00FF;
        push(1'b1, 16'h00FF);
        push(1'b1, 16'h00FF);
        push(1'b1, 16'h00FF);
        for (int i = 0; i < 6; i++) begin
            step();
            check("single_bready", {31'd0, BReady}, (i % 2 == 0) ? 32'd1 : 32'd0);
            if (i % 2 == 1) check("single_pri", {31'd0, dbg_pri}, 32'd0);
            if (i == 5) BValid = 1'b0;
        end

        // Abort: A granted, then withdraws without being accepted.
        step();
        AValid   = 1'b1;
        AData    = 16'h5A5A;
        OutReady = 1'b0;
        step();
        check("abort_granted", {31'd0, OutValid}, 32'd1);
        AValid = 1'b0;
        #1;
        check("abort_outvalid", {31'd0, OutValid}, 32'd0);
        step();
        check("abort_state", {30'd0, dbg_state}, 32'd0);
        check("abort_pri",   {31'd0, dbg_pri},   32'd0);

        // Reset while A holds the grant.
        AValid = 1'b1;
        step();
        check("midrst_granted", {30'd0, dbg_state}, 32'd1);
        Rst_n = 1'b0;
        step();
        check("midrst_state",    {30'd0, dbg_state}, 32'd0);
        check("midrst_outvalid", {31'd0, OutValid},  32'd0);
        check("midrst_select",   {31'd0, Select},    32'd0);
        Rst_n    = 1'b1;
        AValid   = 1'b0;
        OutReady = 1'b1;

`ifdef MUX_ARB_STATS_EN
        // Stats: 20 A transfers saturate a 4-bit counter.
        step();
        AValid = 1'b1;
        AData  = 16'h0011;
        for (int i = 0; i < 20; i++) push(1'b0, 16'h0011);
        repeat (40) step();
        AValid = 1'b0;
        check("stats_acount", {28'd0, ACount}, 32'hF);
        check("stats_bcount", {28'd0, BCount}, 32'h0);
        Rst_n = 1'b0;
        step();
        check("stats_rst_acount", {28'd0, ACount}, 32'h0);
        check("stats_rst_bcount", {28'd0, BCount}, 32'h0);
        Rst_n = 1'b1;
`endif

        repeat (3) step();
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
